cost_word_packer: RTL and testbench

- Transmit-side producer for the 4-to-1 cost compare stage.
- Accepts per-pixel matching costs streamed as narrow beats from the cost-computation unit. Assembles them into one 1280-bit word of 256 five-bit costs (64 groups of 4).
- Presents the word with a valid flag that advances only on the downstream clken.
- Provides a ready/valid input handshake and a two-deep buffer (assembly and output) so the upstream path rarely stalls.

---
 rtl/cost_word_packer_pkg.sv | 27 ++
 rtl/cost_word_outreg.sv | 40 ++++
 rtl/cost_word_packer.sv | 108 ++++++++++
 tb/tb_cost_word_packer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cost_word_packer_pkg.sv
// Shared constants for the cost word packer and the 4-to-1 cost compare stage.
// Defaults for cost width, costs per word and costs per input beat, the derived
// beat count and counter width, the padding cost and the compare group size.
package cost_word_packer_pkg;

    localparam int DEF_COST_W     = 5;
    localparam int DEF_NUM_COST   = 256;
    localparam int DEF_BEAT_COSTS = 16;

    // Number of input beats that make up one full output word
    localparam int DEF_NBEAT = DEF_NUM_COST / DEF_BEAT_COSTS;

    // Padding cost: all ones, so a padded slot never wins a minimum
    localparam logic [DEF_COST_W-1:0] COST_PAD = 5'h1F;

    // The compare stage reduces groups of this many costs
    localparam int GROUP_COSTS   = 4;
    localparam int DEF_NUM_GROUP = DEF_NUM_COST / GROUP_COSTS;

    // Beat counter width; at least one bit even for a single-beat word
    function automatic int calc_bcnt_w(input int nbeat);
        return (nbeat > 1) ? $clog2(nbeat) : 1;
    endfunction

    localparam int DEF_BCNT_W = calc_bcnt_w(DEF_NBEAT);

endpackage

// File: rtl/cost_word_outreg.sv
// Output register of the cost word packer. Holds one complete word and its
// valid flag; the word is consumed on clken && valid. A load in the same cycle
// as a consume replaces the word without a bubble.
module cost_word_outreg
    import cost_word_packer_pkg::*;
#(
    parameter int WORD_W = DEF_NUM_COST * DEF_COST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    output logic [WORD_W-1:0] cost_out,
    output logic              valid,
    output logic              out_free
);

    logic [WORD_W-1:0] word_p1;
    logic              vld_p1;

    // ---- output stage: load a new word, or drop valid once consumed ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            word_p1 <= load_word;
        end else if (clken && vld_p1) begin
            vld_p1  <= 1'b0;
        end
    end

    // Register can accept a word when empty or when its word leaves this cycle
    assign out_free = !vld_p1 || clken;
    assign cost_out = word_p1;
    assign valid    = vld_p1;

endmodule

// File: rtl/cost_word_packer.sv
// Cost word packer: assembles narrow cost beats from the cost-computation unit
// into one wide word of NUM_COST costs for the 4-to-1 compare stage.
// Two-deep buffering (assembly buffer + output register) keeps the input
// streaming at one beat per cycle while the output waits on clken.
// Optional build macro COST_PAD_EN: an early in_last completes the word and
// fills every unwritten cost with all-ones; without it in_last is ignored.
module cost_word_packer
    import cost_word_packer_pkg::*;
#(
    parameter int COST_W     = DEF_COST_W,
    parameter int NUM_COST   = DEF_NUM_COST,
    parameter int BEAT_COSTS = DEF_BEAT_COSTS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BEAT_COSTS*COST_W-1:0] in_cost,
    input  logic                         in_last,
    input  logic                         clken,
    output logic [NUM_COST*COST_W-1:0]   cost_out,
    output logic                         valid
);

    localparam int NBEAT  = NUM_COST / BEAT_COSTS;
    localparam int BCNT_W = calc_bcnt_w(NBEAT);
    localparam int BEAT_W = BEAT_COSTS * COST_W;
    localparam int WORD_W = NUM_COST * COST_W;

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEAT - 1);

`ifdef COST_PAD_EN
    // Every cost of a padded beat is all-ones (COST_PAD at the default width)
    localparam logic [BEAT_W-1:0] PAD_BEAT = '1;
`endif

    logic [BCNT_W-1:0] bcnt_p0;
    logic              full_p0;
    logic [WORD_W-1:0] asm_p0;

    logic out_free;
    logic accept;
    logic complete;
    logic xfer;

    // The assembly word may advance when empty or when it drains this cycle;
    // only registered state and clken feed this, never in_valid.
    assign in_ready = !full_p0 || out_free;
    assign accept   = in_valid && in_ready;
    assign xfer     = full_p0 && out_free;

`ifdef COST_PAD_EN
    assign complete = accept && ((bcnt_p0 == LAST_BEAT) || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign complete = accept && (bcnt_p0 == LAST_BEAT);
`endif

    // ---- assembly control: beat counter and word-complete flag ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_p0 <= '0;
            full_p0 <= 1'b0;
        end else begin
            if (accept) begin
                bcnt_p0 <= complete ? '0 : bcnt_p0 + 1'b1;
            end
            if (complete) begin
                full_p0 <= 1'b1;
            end else if (xfer) begin
                full_p0 <= 1'b0;
            end
        end
    end

    // Assembly data: write the accepted beat into its slot (and pad the tail
    // on an early last). A beat 0 landing while the previous word transfers
    // is safe: the output register samples the old contents at the same edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NBEAT; i++) begin
                if (BCNT_W'(i) == bcnt_p0) begin
                    asm_p0[i*BEAT_W +: BEAT_W] <= in_cost;
`ifdef COST_PAD_EN
                end else if (in_last && (BCNT_W'(i) > bcnt_p0)) begin
                    asm_p0[i*BEAT_W +: BEAT_W] <= PAD_BEAT;
`endif
                end
            end
        end
    end

    // ---- output stage ----
    cost_word_outreg #(
        .WORD_W (WORD_W)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .load      (xfer),
        .load_word (asm_p0),
        .cost_out  (cost_out),
        .valid     (valid),
        .out_free  (out_free)
    );

endmodule

// File: tb/tb_cost_word_packer.sv
// Directed bench for cost_word_packer: reset mid-word, single word latency,
// back-pressure ordering, back-to-back streaming and early in_last handling.
module tb_cost_word_packer;

    localparam int CW = 5;
    localparam int NC = 256;
    localparam int BC = 16;
    localparam int NB = NC / BC;
    localparam int BW = BC * CW;
    localparam int WW = NC * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_cost = '0;
    logic          in_last = 1'b0;
    logic          clken = 1'b0;
    logic [WW-1:0] cost_out;
    logic          valid;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [WW-1:0] got_q[$];
    int            cyc_q[$];
    bit            ready_low;
    bit            w3_done;

    always #5 clk = ~clk;

    cost_word_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cost  (in_cost),
        .in_last  (in_last),
        .clken    (clken),
        .cost_out (cost_out),
        .valid    (valid)
    );

    // Record every consumed word and when it left; note any in_ready drop
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst && valid && clken) begin
            got_q.push_back(cost_out);
            cyc_q.push_back(cyc);
        end
        if (rst && !in_ready) ready_low <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic logic [CW-1:0] pat(input int n, input int k);
        if (n == 0) return CW'(k % 32);
        return CW'((k * 7 + n * 5) % 32);
    endfunction

    function automatic logic [WW-1:0] mk_word(input int n);
        logic [WW-1:0] w;
        for (int k = 0; k < NC; k++) w[k*CW +: CW] = pat(n, k);
        return w;
    endfunction

    function automatic int first_diff(input logic [WW-1:0] a, input logic [WW-1:0] b);
        for (int k = 0; k < NC; k++)
            if (a[k*CW +: CW] !== b[k*CW +: CW]) return k;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded)
    task automatic send_beat(input logic [BW-1:0] data, input logic last);
        int  guard;
        logic acc;
        guard    = 0;
        in_valid = 1'b1;
        in_cost  = data;
        in_last  = last;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 300) begin
                tests++;
                fails++;
                $display("FAIL beat_accept_timeout: in_ready=%0b, want beat accepted", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int first, input int last_b);
        for (int b = first; b <= last_b; b++) send_beat(w[b*BW +: BW], 1'b0);
    endtask

    task automatic test_reset();
        logic [WW-1:0] w;
        clken = 1'b1;
        #2;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", valid); end
        tests++; if (cost_out !== '0) begin fails++; $display("FAIL reset_cost_out: got nonzero, want 0"); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tick();
        rst = 1'b1;
        tick();
        w = mk_word(3);
        send_word(w, 0, 4);
        rst = 1'b0;
        #2;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %0b want 0", valid); end
        tick();
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %0b want 1", in_ready); end
        rst = 1'b1;
        tick();
        got_q.delete();
        w = mk_word(0);
        send_word(w, 0, NB - 1);
        repeat (3) tick();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL postreset_count: got %0d words want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            tests++;
            if (got_q[0] !== w) begin
                fails++;
                $display("FAIL postreset_word: cost %0d got %h want %h", first_diff(got_q[0], w),
                         got_q[0][first_diff(got_q[0], w)*CW +: CW], w[first_diff(got_q[0], w)*CW +: CW]);
            end
        end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL postreset_idle_valid: got %0b want 0", valid); end
    endtask

    task automatic test_full_word();
        logic [WW-1:0] w;
        clken = 1'b1;
        got_q.delete();
        w = mk_word(0);
        send_word(w, 0, NB - 1);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %0b want 0", valid); end
        tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL full_latency_valid: got %0b want 1", valid); end
        tests++;
        if (cost_out !== w) begin
            fails++;
            $display("FAIL full_word: cost %0d got %h want %h", first_diff(cost_out, w),
                     cost_out[first_diff(cost_out, w)*CW +: CW], w[first_diff(cost_out, w)*CW +: CW]);
        end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL full_pulse_width: got %0b want 0", valid); end
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL full_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_back_pressure();
        logic [WW-1:0] w[3];
        int g;
        for (int n = 0; n < 3; n++) w[n] = mk_word(n + 1);
        clken = 1'b0;
        got_q.delete();
        send_word(w[0], 0, NB - 1);
        tick();
        tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: got %0b want 1", valid); end
        tests++; if (cost_out !== w[0]) begin fails++; $display("FAIL bp_hold_word1: cost %0d differs", first_diff(cost_out, w[0])); end
        send_word(w[1], 0, NB - 1);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        w3_done = 1'b0;
        fork
            begin
                send_word(w[2], 0, NB - 1);
                w3_done = 1'b1;
            end
        join_none
        repeat (5) tick();
        tests++; if (cost_out !== w[0]) begin fails++; $display("FAIL bp_still_word1: cost %0d differs", first_diff(cost_out, w[0])); end
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL bp_no_consume: got %0d words want 0", got_q.size()); end
        clken = 1'b1;
        g = 0;
        while (!w3_done && g < 300) begin tick(); g++; end
        tests++; if (!w3_done) begin fails++; $display("FAIL bp_word3_timeout: done=%0b want 1", w3_done); end
        repeat (4) tick();
        tests++; if (got_q.size() != 3) begin fails++; $display("FAIL bp_count: got %0d words want 3", got_q.size()); end
        for (int n = 0; n < 3; n++) begin
            if (got_q.size() > n) begin
                tests++;
                if (got_q[n] !== w[n]) begin
                    fails++;
                    $display("FAIL bp_order_word%0d: cost %0d got %h want %h", n + 1, first_diff(got_q[n], w[n]),
                             got_q[n][first_diff(got_q[n], w[n])*CW +: CW], w[n][first_diff(got_q[n], w[n])*CW +: CW]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int span;
        clken = 1'b1;
        tick();
        got_q.delete();
        cyc_q.delete();
        ready_low = 1'b0;
        start = cyc;
        for (int n = 4; n < 7; n++) send_word(mk_word(n), 0, NB - 1);
        span = cyc - start;
        repeat (4) tick();
        tests++; if (span != 3 * NB) begin fails++; $display("FAIL b2b_span: got %0d cycles want %0d", span, 3 * NB); end
        tests++; if (ready_low !== 1'b0) begin fails++; $display("FAIL b2b_ready: in_ready dropped, want always 1"); end
        tests++; if (got_q.size() != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
        if (got_q.size() == 3) begin
            for (int n = 0; n < 3; n++) begin
                tests++;
                if (got_q[n] !== mk_word(n + 4)) begin
                    fails++;
                    $display("FAIL b2b_word%0d: cost %0d differs", n, first_diff(got_q[n], mk_word(n + 4)));
                end
            end
            tests++; if (cyc_q[1] - cyc_q[0] != NB) begin fails++; $display("FAIL b2b_gap1: got %0d want %0d", cyc_q[1] - cyc_q[0], NB); end
            tests++; if (cyc_q[2] - cyc_q[1] != NB) begin fails++; $display("FAIL b2b_gap2: got %0d want %0d", cyc_q[2] - cyc_q[1], NB); end
        end
    endtask

    task automatic test_early_last();
        logic [WW-1:0] e;
        clken = 1'b1;
        got_q.delete();
        for (int b = 0; b < 4; b++) send_beat('0, (b == 3));
        repeat (3) tick();
`ifdef COST_PAD_EN
        e = '1;
        e[64*CW-1:0] = '0;
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL pad_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            tests++;
            if (got_q[0] !== e) begin
                fails++;
                $display("FAIL pad_word: cost %0d got %h want %h", first_diff(got_q[0], e),
                         got_q[0][first_diff(got_q[0], e)*CW +: CW], e[first_diff(got_q[0], e)*CW +: CW]);
            end
        end
        send_word(mk_word(0), 0, NB - 1);
        repeat (3) tick();
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL pad_next_count: got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            tests++;
            if (got_q[1] !== mk_word(0)) begin fails++; $display("FAIL pad_next_word: cost %0d differs", first_diff(got_q[1], mk_word(0))); end
        end
`else
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL nopad_early: got %0d words want 0", got_q.size()); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL nopad_valid: got %0b want 0", valid); end
        e = mk_word(2);
        e[64*CW-1:0] = '0;
        send_word(e, 4, NB - 1);
        repeat (3) tick();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL nopad_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            tests++;
            if (got_q[0] !== e) begin
                fails++;
                $display("FAIL nopad_word: cost %0d got %h want %h", first_diff(got_q[0], e),
                         got_q[0][first_diff(got_q[0], e)*CW +: CW], e[first_diff(got_q[0], e)*CW +: CW]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_pressure();
        test_back_to_back();
        test_early_last();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
